// File: rtl/gray_move_scheduler.sv
// gray_move_scheduler
//
// Shares one POS_W-bit up/down position counter between two requesters.
// Each requester issues a move command made of a direction and a step count.
// A round-robin arbiter grants one command at a time. The counter then
// advances one step per cycle, the owner gets a one-cycle done pulse, and
// the position is published in binary and in Gray code.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   reqN_valid/dir/steps  command from requester N (dir 1 = up, 0 = down)
//   reqN_ready            requester N command accepted when high with valid
//   reqN_done             one-cycle pulse when requester N's command finishes
//   step_en, step_dir     high / direction for each cycle the position moves
//   pos_bin, pos_gray     current position, binary and Gray
//   busy                  high while a command is in MOVE or DONE
//   grant_id              requester owning the current or last command
//   dbg_state             FSM state (0 IDLE, 1 MOVE, 2 DONE)
//
// Handshake: a command transfers on a rising edge where reqN_valid and
// reqN_ready are both high. Ready is a combinational function of the valids
// and the arbiter state, is only ever high in IDLE, and is high for at most
// one requester. The payload (dir, steps) is sampled only on that edge, and
// changes to valid or payload afterwards have no effect.
module gray_move_scheduler #(
    parameter int CNT_W = 3,
    parameter int POS_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_dir,
    input  logic [CNT_W-1:0] req0_steps,
    output logic             req0_ready,
    output logic             req0_done,
    input  logic             req1_valid,
    input  logic             req1_dir,
    input  logic [CNT_W-1:0] req1_steps,
    output logic             req1_ready,
    output logic             req1_done,
    output logic             step_en,
    output logic             step_dir,
    output logic [POS_W-1:0] pos_bin,
    output logic [POS_W-1:0] pos_gray,
    output logic             busy,
    output logic             grant_id,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_dir;
    logic               r_step_en;
    logic               r_busy;
    logic [1:0]         r_done;
    logic               r_grant;
    logic               r_last_grant;

    logic               w_idle;
    logic               w_pick1;
    logic               w_accept;
    logic               w_dir;
    logic [CNT_W-1:0]   w_steps;

    // Requester 1 wins when it is the only one valid, or on a tie when
    // requester 0 held the previous grant.
    always_comb begin
        w_idle   = (r_state == ST_IDLE);
        w_pick1  = req1_valid & (~req0_valid | ~r_last_grant);
        w_accept = w_idle & (req0_valid | req1_valid);
        w_dir    = w_pick1 ? req1_dir   : req0_dir;
        w_steps  = w_pick1 ? req1_steps : req0_steps;
    end

    assign req0_ready = w_idle & req0_valid & ~w_pick1;
    assign req1_ready = w_idle & w_pick1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pos        <= '0;
            r_remaining  <= '0;
            r_dir        <= 1'b0;
            r_step_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 2'b00;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 2'b00;
                    if (w_accept) begin
                        r_dir        <= w_dir;
                        r_remaining  <= w_steps;
                        r_grant      <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_busy       <= 1'b1;
                        if (w_steps != '0) begin
                            r_state   <= ST_MOVE;
                            r_step_en <= 1'b1;
                        end else begin
                            // Zero-step command completes without moving.
                            r_state <= ST_DONE;
                            r_done  <= w_pick1 ? 2'b10 : 2'b01;
                        end
                    end
                end
                ST_MOVE: begin
                    // Counter wraps naturally modulo 2^POS_W in both directions.
                    r_pos       <= r_dir ? r_pos + POS_W'(1) : r_pos - POS_W'(1);
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state   <= ST_DONE;
                        r_step_en <= 1'b0;
                        r_done    <= r_grant ? 2'b10 : 2'b01;
                    end
                end
                ST_DONE: begin
                    r_done  <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_done = r_done[0];
    assign req1_done = r_done[1];
    assign step_en   = r_step_en;
    assign step_dir  = r_dir;
    assign pos_bin   = r_pos;
    assign pos_gray  = r_pos ^ (r_pos >> 1);
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gray_move_scheduler.sv
// Testbench for gray_move_scheduler: table of commands with hand-derived
// grant and end position, a queue of expected per-step positions, a mid-move
// reset sequence and a short random tail.
module tb_gray_move_scheduler;

    localparam int CNT_W = 3;
    localparam int POS_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_dir, req0_ready, req0_done;
    logic [CNT_W-1:0] req0_steps;
    logic             req1_valid, req1_dir, req1_ready, req1_done;
    logic [CNT_W-1:0] req1_steps;
    logic             step_en, step_dir, busy, grant_id;
    logic [POS_W-1:0] pos_bin, pos_gray;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    gray_move_scheduler #(.CNT_W(CNT_W), .POS_W(POS_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_dir   (req0_dir),
        .req0_steps (req0_steps),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req1_valid (req1_valid),
        .req1_dir   (req1_dir),
        .req1_steps (req1_steps),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .step_en    (step_en),
        .step_dir   (step_dir),
        .pos_bin    (pos_bin),
        .pos_gray   (pos_gray),
        .busy       (busy),
        .grant_id   (grant_id),
        .dbg_state  (dbg_state)
    );

    typedef struct {
        logic             rst;        // apply reset before this command
        logic             hold;       // keep valids asserted after accept
        logic             v0;
        logic             d0;
        logic [CNT_W-1:0] s0;
        logic             v1;
        logic             d1;
        logic [CNT_W-1:0] s1;
        logic             exp_grant;
        logic [POS_W-1:0] exp_pos;    // position after the command
    } vec_t;

    vec_t             vecs[11];
    logic [POS_W-1:0] exp_q[$];
    logic [1:0]       done_q[$];
    int               n_vec  = 0;
    int               n_fail = 0;
    logic [POS_W-1:0] m_pos;
    logic             m_last;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0; req0_dir = 1'b0; req0_steps = '0;
        req1_valid = 1'b0; req1_dir = 1'b0; req1_steps = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        m_pos  = '0;
        m_last = 1'b1;
        #1;
        check("rst_pos_bin",  pos_bin, 0);
        check("rst_pos_gray", pos_gray, 0);
        check("rst_flags",    {step_en, step_dir, busy, req1_done, req0_done}, 0);
        check("rst_grant_id", grant_id, 0);
    endtask

    // Drives one command in an IDLE cycle and checks every cycle up to and
    // including its done pulse.
    task automatic run_cmd(input vec_t v);
        logic             win, dir;
        logic [CNT_W-1:0] steps;
        logic [POS_W-1:0] p, e, prev_g;
        @(negedge clk);
        req0_valid = v.v0; req0_dir = v.d0; req0_steps = v.s0;
        req1_valid = v.v1; req1_dir = v.d1; req1_steps = v.s1;
        #1;
        win   = (v.v0 && v.v1) ? ~m_last : v.v1;
        dir   = win ? v.d1 : v.d0;
        steps = win ? v.s1 : v.s0;
        check("idle_busy", busy, 0);
        check("ready0", req0_ready, v.v0 && !win);
        check("ready1", req1_ready, win);
        p = m_pos;
        for (int k = 1; k <= int'(steps); k++) begin
            p = dir ? p + 3'd1 : p - 3'd1;
            exp_q.push_back(p);
        end
        done_q.push_back(win ? 2'b10 : 2'b01);
        m_last = win;
        prev_g = pos_gray;
        @(posedge clk);
        if (!v.hold) begin
            #1;
            req0_valid = 1'b0; req0_dir = ~req0_dir; req0_steps = CNT_W'($urandom_range(0, 7));
            req1_valid = 1'b0; req1_dir = ~req1_dir; req1_steps = CNT_W'($urandom_range(0, 7));
        end
        for (int k = 1; k <= int'(steps) + 1; k++) begin
            @(negedge clk);
            check("busy", busy, 1);
            check("ready_low", {req1_ready, req0_ready}, 0);
            check("grant_id", grant_id, v.exp_grant);
            check("step_en", step_en, k <= int'(steps));
            if (k <= int'(steps)) begin
                check("step_dir", step_dir, dir);
                check("no_early_done", {req1_done, req0_done}, 0);
            end else begin
                check("done", {req1_done, req0_done}, done_q.pop_front());
            end
            if (k == 1) begin
                check("pos_hold", pos_bin, m_pos);
            end else begin
                e = exp_q.pop_front();
                check("pos_bin", pos_bin, e);
                check("pos_gray", pos_gray, e ^ (e >> 1));
                check("gray_1bit", $countones(pos_gray ^ prev_g), 1);
                prev_g = pos_gray;
            end
        end
        check("end_pos", pos_bin, v.exp_pos);
        check("exp_q_empty", exp_q.size(), 0);
        m_pos = p;
    endtask

    initial begin
        vec_t r;
        //            rst  hold v0 d0 s0    v1 d1 s1    grant pos
        vecs[0]  = '{1'b1, 1'b0, 1, 1, 3'd5, 0, 0, 3'd0, 1'b0, 3'd5}; // up 5
        vecs[1]  = '{1'b1, 1'b0, 0, 0, 3'd0, 1, 0, 3'd3, 1'b1, 3'd5}; // down 3 from 0
        vecs[2]  = '{1'b1, 1'b1, 1, 1, 3'd2, 1, 0, 3'd1, 1'b0, 3'd2}; // tie -> req0
        vecs[3]  = '{1'b0, 1'b1, 1, 1, 3'd2, 1, 0, 3'd1, 1'b1, 3'd1}; // tie -> req1
        vecs[4]  = '{1'b0, 1'b1, 1, 1, 3'd2, 1, 0, 3'd1, 1'b0, 3'd3}; // tie -> req0
        vecs[5]  = '{1'b0, 1'b1, 1, 1, 3'd2, 1, 0, 3'd1, 1'b1, 3'd2}; // tie -> req1
        vecs[6]  = '{1'b0, 1'b0, 1, 1, 3'd1, 0, 0, 3'd0, 1'b0, 3'd3}; // to pos 3
        vecs[7]  = '{1'b0, 1'b0, 1, 1, 3'd0, 0, 0, 3'd0, 1'b0, 3'd3}; // zero steps
        vecs[8]  = '{1'b1, 1'b0, 1, 1, 3'd7, 0, 0, 3'd0, 1'b0, 3'd7}; // up 7
        vecs[9]  = '{1'b0, 1'b0, 1, 1, 3'd2, 0, 0, 3'd0, 1'b0, 3'd1}; // wrap 7->0->1
        vecs[10] = '{1'b0, 1'b0, 0, 0, 3'd0, 1, 1, 3'd0, 1'b1, 3'd1}; // req1 zero steps

        do_reset();
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) do_reset();
            run_cmd(vecs[i]);
        end

        // Random commands; expectations come from the arbitration model.
        for (int i = 0; i < 8; i++) begin
            r.rst  = 1'b0;
            r.hold = 1'($urandom_range(0, 1));
            r.v0   = 1'($urandom_range(0, 1));
            r.v1   = r.v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            r.d0   = 1'($urandom_range(0, 1));
            r.d1   = 1'($urandom_range(0, 1));
            r.s0   = CNT_W'($urandom_range(0, 7));
            r.s1   = CNT_W'($urandom_range(0, 7));
            r.exp_grant = (r.v0 && r.v1) ? ~m_last : r.v1;
            if (r.exp_grant)
                r.exp_pos = r.d1 ? m_pos + r.s1 : m_pos - r.s1;
            else
                r.exp_pos = r.d0 ? m_pos + r.s0 : m_pos - r.s0;
            run_cmd(r);
        end

        // Reset during the 3rd step of an up-6 move.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 3'd6;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_pos_before_reset", pos_bin, 2);
        #1 reset = 1'b1;
        #1;
        check("abort_pos_bin", pos_bin, 0);
        check("abort_busy", busy, 0);
        check("abort_step_en", step_en, 0);
        check("abort_done", {req1_done, req0_done}, 0);
        @(negedge clk);
        check("abort_no_done", {req1_done, req0_done}, 0);
        reset = 1'b0;
        req0_valid = 1'b1; req0_dir = 1'b1; req0_steps = 3'd2;
        #1;
        check("post_reset_ready0", req0_ready, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy, 1);
        check("post_reset_step_en", step_en, 1);
        @(negedge clk);
        check("post_reset_pos1", pos_bin, 1);
        @(negedge clk);
        check("post_reset_done", {req1_done, req0_done}, 2'b01);
        check("post_reset_pos2", pos_bin, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_move_scheduler.md
# gray_move_scheduler

Round-robin scheduler that shares one 3-bit up/down position counter between two requesters. Each requester issues a move command: a direction and a step count. The block grants one command at a time and sequences the counter one step per cycle. It then reports completion to the owner and publishes the position in binary and Gray code. It sits between the command sources and any logic that consumes the Gray-coded position.

## Interface
Parameters:
- CNT_W, 3, width of the step-count field per command
- POS_W, 3, width of the position counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req0_valid  in  1  requester 0 command valid
- req0_dir  in  1  1 = count up, 0 = count down
- req0_steps  in  CNT_W  number of steps, 0..2^CNT_W-1
- req0_ready  out  1  requester 0 command accepted this cycle when high with valid
- req0_done  out  1  one-cycle pulse, requester 0 command finished
- req1_valid, req1_dir, req1_steps, req1_ready, req1_done  same as requester 0
- step_en  out  1  high during each cycle in which the position advances
- step_dir  out  1  direction of the current move
- pos_bin  out  POS_W  current position
- pos_gray  out  POS_W  pos_bin ^ (pos_bin >> 1)
- busy  out  1  high in MOVE and DONE
- grant_id  out  1  requester owning the current or last command

## Operation
- States: IDLE, MOVE, DONE.
- IDLE:
  - Arbitration is combinational over the valid inputs.
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester not named in last_grant.
  - The winner's ready is high; the other ready is low.
  - Ready is never high outside IDLE.
- Accept means valid & ready at a rising edge. On accept:
  - Latch dir and steps into the block.
  - Set grant_id and last_grant to the winner.
  - If steps ≠ 0, go to MOVE with remaining = steps.
  - If steps = 0, go straight to DONE.
- MOVE:
  - step_en = 1 and step_dir = latched dir.
  - Each cycle, pos_bin increments or decrements by one, modulo 2^POS_W, and remaining decrements.
  - When remaining = 1 at the edge, go to DONE.
- DONE:
  - step_en = 0.
  - reqN_done = 1 for grant_id only, for exactly one cycle.
  - Return to IDLE.
- Command payload is sampled only at accept. Changes to valid, dir or steps after accept have no effect.
- Position wrap-around:
  - Up from 2^POS_W-1 goes to 0.
  - Down from 0 goes to 2^POS_W-1.
  - No saturation and no error flag.
- Consecutive Gray values differ in exactly one bit, including across the wrap.
- pos_bin holds its value between commands. Only reset clears it.

## Timing
- Reset values:
  - State IDLE, pos_bin = 0, pos_gray = 0.
  - step_en, step_dir, busy, reqN_done = 0.
  - grant_id = 0, last_grant = 1, so requester 0 wins the first tie.
- Accept at edge T with steps = S > 0:
  - step_en is high in cycles T+1 through T+S.
  - pos_bin shows the k-th step's value after edge T+k.
  - done is high in cycle T+S+1.
  - IDLE is reached at T+S+2, and the next accept is possible at that edge.
- Accept at edge T with steps = 0: done is high in cycle T+1, no step_en, pos unchanged.
- Command throughput is S+2 cycles per command.
- busy is high from T+1 through the done cycle inclusive.
- pos_bin and pos_gray are registered, or derived combinationally from the registered pos_bin. No added latency versus pos_bin.
- Reset asserted mid-move:
  - Immediate return to IDLE with all reset values.
  - No done pulse is issued for the aborted command.
  - The requester must reissue it.

## Test plan
- After reset, req0 sends up, 5 steps. Required: step_en for 5 cycles, pos_bin 1,2,3,4,5, final pos_gray = 111, req0_done one cycle after the last step, req1_done stays 0.
- From pos 0, req1 sends down, 3 steps. Required: pos_bin 7,6,5; pos_gray 100,101,111; step_dir = 0 throughout.
- Both valid, held, immediately after reset. Required: req0 served first and req1 second. A further tie then goes to req0, so service alternates. grant_id follows the service order.
- req0 sends steps = 0 at pos 3. Required: req0_done at T+1, step_en never high, pos_bin stays 3.
- Up 7 steps, then up 2 steps, from 0. Required: wrap 7→0, pos_bin ends at 1, and every consecutive pos_gray pair differs in exactly one bit.
- Reset asserted during the 3rd step of an up-6 move. Required: pos_bin = 0, busy = 0, no done pulse, and a new command is accepted on the first edge after reset deasserts.
